beat_sequencer: RTL and testbench

- Playback controller for the music player: steps the beat index through the song ROM at the tempo chosen by the speed selection.
- Replaces per-speed derived play clocks with a single-clock beat_tick enable.
- Owns play/pause/stop state, song selection and looping.
- Downstream tone/ROM logic consumes rom_addr and beat_tick, all on clk.

---
 rtl/beat_sequencer.sv | 149 ++++++++++++++
 tb/tb_beat_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/beat_sequencer.sv
// Beat sequencer: steps {song_id, beat_idx} through the song ROM on a single-clock beat_tick enable.
// Optional reverse playback is compiled in with BEAT_SEQUENCER_REVERSE_EN.
module beat_sequencer #(
  parameter int NORMAL_LOG2 = 24,
  parameter int ADDR_W      = 7,
  parameter int SONG_LEN    = 128,
  parameter int SONG_W      = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               speed,
  input  logic                     play_pause,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic [SONG_W-1:0]        song_sel,
  input  logic                     reverse,
  output logic [SONG_W+ADDR_W-1:0] rom_addr,
  output logic [ADDR_W-1:0]        beat_idx,
  output logic [SONG_W-1:0]        song_id,
  output logic                     beat_tick,
  output logic                     song_done,
  output logic                     playing,
  output logic                     paused
);

  localparam int CNT_W = NORMAL_LOG2 + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SONG_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next, period_m1;
  logic [ADDR_W-1:0]   idx_reg, idx_next;
  logic [SONG_W-1:0]   song_reg, song_next;
  logic                tick_reg, tick_next;
  logic                done_reg, done_next;
  logic                playing_reg, paused_reg;
  logic                song_change, clear, tick_due, at_end, going_back;

`ifdef BEAT_SEQUENCER_REVERSE_EN
  assign going_back = reverse;
`else
  logic unused_reverse;
  assign unused_reverse = reverse;
  assign going_back     = 1'b0;
`endif

  // Terminal count is P-1; all three periods are powers of two, so these are all-ones masks.
  always_comb begin
    case (speed)
      2'd3:    period_m1 = {2'b00, {(NORMAL_LOG2-1){1'b1}}};
      2'd2:    period_m1 = {1'b0, {NORMAL_LOG2{1'b1}}};
      default: period_m1 = {CNT_W{1'b1}};
    endcase
  end

  assign song_change = (song_sel != song_reg);
  assign clear       = stop | song_change;
  // >= rather than == so a mid-beat speed-up past the new terminal count fires at once.
  assign tick_due    = (state_reg == PLAY) && (cnt_reg >= period_m1);
  assign at_end      = going_back ? (idx_reg == '0) : (idx_reg == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      song_reg    <= '0;
      tick_reg    <= 1'b0;
      done_reg    <= 1'b0;
      playing_reg <= 1'b0;
      paused_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      song_reg    <= song_next;
      tick_reg    <= tick_next;
      done_reg    <= done_next;
      playing_reg <= (state_next == PLAY);
      paused_reg  <= (state_next == PAUSE);
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = IDLE;
    end else if (play_pause) begin
      case (state_reg)
        IDLE:    state_next = PLAY;
        PLAY:    state_next = PAUSE;
        PAUSE:   state_next = PLAY;
        default: state_next = IDLE;
      endcase
    end else if (tick_due && at_end && !loop_en) begin
      state_next = IDLE;
    end
  end

  // Priority: stop / song change, then play_pause, then beat stepping.
  always_comb begin
    cnt_next  = cnt_reg;
    idx_next  = idx_reg;
    song_next = song_reg;
    tick_next = 1'b0;
    done_next = 1'b0;
    if (clear) begin
      cnt_next  = '0;
      idx_next  = '0;
      song_next = song_sel;
    end else if (play_pause) begin
      if (state_reg == IDLE) begin
        cnt_next = '0;
        if (going_back) begin
          idx_next = LAST_IDX;
        end
      end
    end else if (state_reg == PLAY) begin
      if (tick_due) begin
        cnt_next  = '0;
        tick_next = 1'b1;
        if (at_end) begin
          done_next = 1'b1;
          idx_next  = (going_back && loop_en) ? LAST_IDX : '0;
        end else if (going_back) begin
          idx_next = idx_reg - ADDR_W'(1);
        end else begin
          idx_next = idx_reg + ADDR_W'(1);
        end
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  assign rom_addr  = {song_reg, idx_reg};
  assign beat_idx  = idx_reg;
  assign song_id   = song_reg;
  assign beat_tick = tick_reg;
  assign song_done = done_reg;
  assign playing   = playing_reg;
  assign paused    = paused_reg;

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer: directed scenarios plus random play against a cycle model.
module tb_beat_sequencer;
  localparam int NL = 4;
  localparam int AW = 3;
  localparam int SL = 8;
  localparam int SW = 2;
  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    speed = 2'd2;
  logic          play_pause = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [SW-1:0] song_sel = '0;
  logic          reverse = 1'b0;
  logic [SW+AW-1:0] rom_addr;
  logic [AW-1:0] beat_idx;
  logic [SW-1:0] song_id;
  logic          beat_tick, song_done, playing, paused;

  int tests = 0;
  int fails = 0;

  // Reference model: player mode, cycles spent in the current beat, beat position, song.
  int m_mode, m_wait, m_beat, m_song;
  bit m_tick, m_done;

  beat_sequencer #(.NORMAL_LOG2(NL), .ADDR_W(AW), .SONG_LEN(SL), .SONG_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .speed(speed), .play_pause(play_pause), .stop(stop),
    .loop_en(loop_en), .song_sel(song_sel), .reverse(reverse), .rom_addr(rom_addr),
    .beat_idx(beat_idx), .song_id(song_id), .beat_tick(beat_tick), .song_done(song_done),
    .playing(playing), .paused(paused)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int period_of(input logic [1:0] s);
    if (s == 2'd3) return 1 << (NL - 1);
    if (s == 2'd2) return 1 << NL;
    return 1 << (NL + 1);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_wait = 0; m_beat = 0; m_song = 0; m_tick = 0; m_done = 0;
  endtask

  task automatic model_clock();
    bit rev;
    rev = 1'b0;
`ifdef BEAT_SEQUENCER_REVERSE_EN
    rev = reverse;
`endif
    m_tick = 0;
    m_done = 0;
    if (stop || int'(song_sel) != m_song) begin
      m_song = int'(song_sel); m_mode = M_IDLE; m_beat = 0; m_wait = 0;
    end else if (play_pause) begin
      if (m_mode == M_IDLE) begin
        m_mode = M_PLAY; m_wait = 0;
        if (rev) m_beat = SL - 1;
      end else if (m_mode == M_PLAY) m_mode = M_PAUSE;
      else m_mode = M_PLAY;
    end else if (m_mode == M_PLAY) begin
      if (m_wait + 1 >= period_of(speed)) begin
        m_wait = 0;
        m_tick = 1;
        if ((rev && m_beat == 0) || (!rev && m_beat == SL - 1)) begin
          m_done = 1;
          if (!loop_en) begin m_mode = M_IDLE; m_beat = 0; end
          else m_beat = rev ? SL - 1 : 0;
        end else begin
          m_beat = (m_beat + (rev ? SL - 1 : 1)) % SL;
        end
      end else begin
        m_wait++;
      end
    end
  endtask

  task automatic check_outputs();
    chk("beat_idx", beat_idx, m_beat);
    chk("song_id", song_id, m_song);
    chk("rom_addr", rom_addr, m_song * (1 << AW) + m_beat);
    chk("beat_tick", beat_tick, m_tick);
    chk("song_done", song_done, m_done);
    chk("playing", playing, m_mode == M_PLAY);
    chk("paused", paused, m_mode == M_PAUSE);
  endtask

  task automatic step(input bit pp, input bit st);
    play_pause = pp;
    stop = st;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_outputs();
    play_pause = 1'b0;
    stop = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step(1'b0, 1'b0);
      n++;
    end while (!beat_tick && n < 400);
    chk("tick_seen", beat_tick, 1);
  endtask

  initial begin
    int n, k, saved, ticks;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Start at normal speed: first tick 16 cycles after the pulse.
    speed = 2'd2; loop_en = 1'b0;
    step(1'b1, 1'b0);
    chk("playing_after_pp", playing, 1);
    wait_tick(n);
    chk("first_tick_latency", n, 16);
    chk("beat_after_first", beat_idx, 1);

    // Speed-up at cnt = 10 fires on the next cycle, then fast and slow periods.
    repeat (10) step(1'b0, 1'b0);
    speed = 2'd3;
    step(1'b0, 1'b0);
    chk("tick_on_speedup", beat_tick, 1);
    wait_tick(n);
    chk("fast_period", n, 8);
    speed = 2'd1;
    wait_tick(n);
    chk("slow_period", n, 32);

    // Run to end of song without looping.
    speed = 2'd3;
    k = 0;
    do begin wait_tick(n); k++; end while (!song_done && k < 20);
    chk("ticks_to_end", k, 4);
    chk("end_beat_idx", beat_idx, 0);
    chk("end_playing", playing, 0);
    ticks = 0;
    repeat (40) begin step(1'b0, 1'b0); ticks += int'(beat_tick); end
    chk("no_ticks_in_idle", ticks, 0);

    // Looping playback wraps and stays in PLAY.
    loop_en = 1'b1;
    step(1'b1, 1'b0);
    k = 0;
    do begin wait_tick(n); k++; end while (!song_done && k < 20);
    chk("ticks_to_wrap", k, 8);
    chk("wrap_beat_idx", beat_idx, 0);
    chk("wrap_playing", playing, 1);

    // Pause at cnt = 5, hold 100 cycles, resume: 11 cycles to the next tick.
    speed = 2'd2;
    wait_tick(n);
    chk("normal_period", n, 16);
    repeat (5) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("paused_flag", paused, 1);
    saved = int'(beat_idx);
    repeat (100) step(1'b0, 1'b0);
    chk("beat_held_in_pause", beat_idx, saved);
    step(1'b1, 1'b0);
    wait_tick(n);
    chk("resume_latency", n, 11);

    // stop beats play_pause in the same cycle.
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("stop_pp_playing", playing, 0);
    chk("stop_pp_beat", beat_idx, 0);

    // Song change while playing behaves as stop.
    step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);
    song_sel = 2'd2;
    step(1'b0, 1'b0);
    chk("song_change_id", song_id, 2);
    chk("song_change_playing", playing, 0);
    chk("song_change_rom_addr", rom_addr, 16);

`ifdef BEAT_SEQUENCER_REVERSE_EN
    loop_en = 1'b1; reverse = 1'b1; speed = 2'd3;
    step(1'b1, 1'b0);
    chk("rev_start_beat", beat_idx, SL - 1);
    wait_tick(n);
    chk("rev_beat_6", beat_idx, 6);
    wait_tick(n);
    chk("rev_beat_5", beat_idx, 5);
    k = 0;
    do begin wait_tick(n); k++; end while (!song_done && k < 20);
    chk("rev_ticks_to_wrap", k, 6);
    chk("rev_wrap_beat", beat_idx, SL - 1);
    chk("rev_wrap_playing", playing, 1);
`else
    reverse = 1'b1; speed = 2'd3;
    step(1'b1, 1'b0);
    chk("rev_ignored_start", beat_idx, 0);
    wait_tick(n);
    chk("rev_ignored_step", beat_idx, 1);
`endif
    reverse = 1'b0;
    step(1'b0, 1'b1);

    // Random play against the model.
    for (int i = 0; i < 900; i++) begin
      bit pp, st;
      if ($urandom_range(0, 29) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) loop_en = ~loop_en;
      if ($urandom_range(0, 79) == 0) reverse = ~reverse;
      if ($urandom_range(0, 199) == 0) song_sel = SW'($urandom_range(0, 3));
      pp = ($urandom_range(0, 24) == 0);
      st = ($urandom_range(0, 149) == 0);
      step(pp, st);
    end

    // Asynchronous reset in the middle of a beat.
    reverse = 1'b0; speed = 2'd2; song_sel = 2'd1;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b0);
    chk("pre_reset_playing", playing, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_beat_tick", beat_tick, 0);
    chk("async_song_done", song_done, 0);
    chk("async_playing", playing, 0);
    chk("async_paused", paused, 0);
    chk("async_beat_idx", beat_idx, 0);
    chk("async_song_id", song_id, 0);
    chk("async_rom_addr", rom_addr, 0);
    model_reset();
    song_sel = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) step(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
